regfile_2r1w_clr: RTL
=====================

# regfile_2r1w_clr

Parametrised MIPS general-purpose register file: two asynchronous read ports, one synchronous write port, and a third asynchronous debug read port. A hardware clear sequencer zeroes every entry after reset and reports completion on `ready`. Optional same-cycle write-to-read bypass lets a pipelined or multicycle datapath read a value in the cycle it is written. Register 0 always reads zero.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth = 2^ADDR_W entries.
- `BYPASS`, 1: 1 = read ports forward same-cycle write data; 0 = read ports return stored contents only.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rs`  in  ADDR_W  read address, port 1.
- `rt`  in  ADDR_W  read address, port 2.
- `data_out1`  out  DATA_W  read data, port 1.
- `data_out2`  out  DATA_W  read data, port 2.
- `rd`  in  ADDR_W  write address.
- `data_in`  in  DATA_W  write data.
- `we`  in  1  write enable.
- `dbg_addr`  in  ADDR_W  debug read address.
- `dbg_data`  out  DATA_W  debug read data; never bypassed.
- `ready`  out  1  high once the clear sequence is complete.

## Operation
- FSM states: CLEAR, RUN.
- `rst_n` low at a rising edge: state <= CLEAR, `clr_cnt` <= 0, `ready` <= 0. Register contents are not modified by that edge.
- CLEAR, `rst_n` high: at each edge, entry[`clr_cnt`] <= 0 and `clr_cnt` increments (ADDR_W+1 bits, no wrap). The edge that clears entry 2^ADDR_W-1 also moves the state to RUN and sets `ready` <= 1.
- CLEAR: `we` is ignored and no user write occurs. `data_out1`, `data_out2` and `dbg_data` are forced to 0.
- RUN: when `we`=1 and `rd`!=0, entry[`rd`] <= `data_in`. A write with `rd`=0 is discarded.
- RUN reads are combinational:
  - `data_out1` = 0 if `rs`=0.
  - Otherwise, if BYPASS=1 and `we`=1 and `rd`=`rs`, `data_out1` = `data_in`.
  - Otherwise, `data_out1` = entry[`rs`].
  - `data_out2` follows the same rules using `rt`.
  - `dbg_data` = entry[`dbg_addr`], or 0 when `dbg_addr`=0.
- Simultaneous read and write to the same address:
  - BYPASS=0: the read returns the old value until the edge.
  - BYPASS=1: the read returns the new value in the same cycle.
- Both read ports may address the same entry; each port is resolved independently.
- Reset in the middle of CLEAR restarts the sequence from entry 0.
- Reset during RUN re-enters CLEAR; all entries are zero again 2^ADDR_W cycles after `rst_n` rises.

## Timing
- Reset values: `ready`=0, `data_out1`=0, `data_out2`=0, `dbg_data`=0. State = CLEAR.
- Clear latency: `ready` rises exactly 2^ADDR_W rising edges after the first edge sampled with `rst_n`=1 (32 edges for ADDR_W=5).
- Write latency: 1 edge. The value is visible on a non-bypassed read in the cycle after the write edge.
- Read latency: 0 cycles (combinational from address, and from `we`/`rd`/`data_in` when BYPASS=1).
- No handshake on the write port: `we` is a single-cycle qualifier, and one write per edge is accepted in RUN.
- Upstream logic must hold `we` low, or tolerate dropped writes, until `ready`=1.
- Every entry is exactly DATA_W bits. Writes do not truncate or extend data; reads return all DATA_W bits of the selected entry.

## Test plan
- Clear sequence, ADDR_W=5:
  - Pre-load with back-door junk, then hold `rst_n`=0 for 3 edges and release.
  - Required: `ready`=0 for 31 edges and 1 after the 32nd edge.
  - Required: reading all 32 addresses on `dbg_data` returns 0.
  - Required: `we`=1 with `rd`=5 and `data_in`=0xDEADBEEF during CLEAR leaves entry 5 at 0.
- Basic write/read:
  - Write 0x12345678 to r9 and 0xCAFEF00D to r31.
  - Required next cycle: `rs`=9, `rt`=31 gives `data_out1`=0x12345678 and `data_out2`=0xCAFEF00D.
- Zero register:
  - `we`=1, `rd`=0, `data_in`=0xFFFFFFFF.
  - Required: `data_out1` with `rs`=0 is 0 in the same cycle and the next; `dbg_data` at address 0 is 0.
- Bypass:
  - r4 holds 0x11. Drive `we`=1, `rd`=4, `data_in`=0x22, `rs`=`rt`=4.
  - Required same cycle, BYPASS=1: both outputs 0x22 and `dbg_data`(4)=0x11.
  - Required same cycle, BYPASS=0: both outputs 0x11.
  - Required after the edge (both settings): 0x22.
- Reset mid-clear and mid-run:
  - Assert `rst_n`=0 for one edge after 10 clear cycles. Required: `ready` rises 32 edges after release.
  - Repeat in RUN after writing r7=0xAA. Required: `ready` drops and r7 reads 0 after re-clear.
- Parameter sweep, DATA_W=16 and ADDR_W=3:
  - Required: `ready` rises after 8 edges.
  - Required: a write of 0xBEEF to r7 reads back 0xBEEF.
  - Required: writing r7 does not change r6 (aliasing check).

Source files
------------

// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr
//   General-purpose register file with two asynchronous read ports, one
//   synchronous write port and an asynchronous debug read port. After reset,
//   a clear sequencer zeroes every entry, one entry per clock, and then raises
//   `ready`. Register 0 always reads as zero. When BYPASS=1, the read ports
//   return the write data in the same cycle that the write is presented.
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   rst_n     - synchronous active-low reset
//   rs, rt    - read addresses for ports 1 and 2
//   data_out1 - read data, port 1
//   data_out2 - read data, port 2
//   rd        - write address
//   data_in   - write data
//   we        - write enable; ignored while clearing
//   dbg_addr  - debug read address
//   dbg_data  - debug read data; never bypassed
//   ready     - high once the clear sequence has finished
module regfile_2r1w_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_n;
    logic              ready_n;
    logic              clr_we;
    logic              usr_we;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
            ready   <= ready_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        ready_n   = ready;
        clr_we    = 1'b0;
        usr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_n = clr_cnt + ONE;
                if (clr_cnt == LAST) begin
                    state_n = RUN;
                    ready_n = 1'b1;
                end
            end
            RUN: begin
                usr_we = we && (rd != '0);
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    // Storage has no reset of its own; the edge that samples rst_n low leaves
    // the contents untouched, and the clear sequencer zeroes them afterwards.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[clr_cnt[ADDR_W-1:0]] <= '0;
            end else if (usr_we) begin
                mem[rd] <= data_in;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (state == RUN && addr != '0) begin
            if (BYPASS != 0 && we && rd == addr) begin
                val = data_in;
            end else begin
                val = mem[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        data_out1 = read_port(rs);
        data_out2 = read_port(rt);
        dbg_data  = '0;
        if (state == RUN && dbg_addr != '0) begin
            dbg_data = mem[dbg_addr];
        end
    end

endmodule
